// File: rtl/common_pkg.sv
// common_pkg: shared sizing, types and state encoding for the operand fetch stage
package common_pkg;
  localparam int SYS_ARRAY_SIZE = 4;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int ROW_BITS = SYS_ARRAY_SIZE * DATA_WIDTH;
  localparam int ROW_BYTES = ROW_BITS / 8;
  localparam int FILL_CYCLES = 3 * SYS_ARRAY_SIZE;
  localparam int CNT_W = $clog2(5 * SYS_ARRAY_SIZE + 1);
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [CNT_W-1:0] fetch_cnt_t;
  typedef enum logic [2:0] {IDLE, READ, COMPUTE, HANDOFF, DRAIN} state_t;
endpackage

// File: rtl/skew_buffer.sv
// skew_buffer: delays lane j by j cycles so operands enter the array diagonally
module skew_buffer
  import common_pkg::*;
(
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  data_t [SYS_ARRAY_SIZE-1:0]       din_i,
  output data_t [SYS_ARRAY_SIZE-1:0]       dout_o
);
  assign dout_o[0] = din_i[0];
  for (genvar j = 1; j < SYS_ARRAY_SIZE; j++) begin : g_lane
    data_t [j-1:0] sr_q, sr_d;
    always_comb begin
      sr_d[0] = din_i[j];
      for (int i = 1; i < j; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) sr_q <= '0;
      else sr_q <= sr_d;
    assign dout_o[j] = sr_q[j-1];
  end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads N rows of A and B, feeds them skewed into the array,
// then hands the C base to the write stage and waits out its drain
module operand_fetch
  import common_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [ADDR_WIDTH-1:0]      addr_a_i,
  input  logic [ADDR_WIDTH-1:0]      addr_b_i,
  input  logic [ADDR_WIDTH-1:0]      addr_c_i,
  output logic                       en_a_o,
  output logic                       en_b_o,
  output logic [ADDR_WIDTH-1:0]      addr_a_o,
  output logic [ADDR_WIDTH-1:0]      addr_b_o,
  input  logic [ROW_BITS-1:0]        rdata_a_i,
  input  logic [ROW_BITS-1:0]        rdata_b_i,
  output logic                       clear_o,
  output data_t [SYS_ARRAY_SIZE-1:0] a_o,
  output data_t [SYS_ARRAY_SIZE-1:0] b_o,
  output logic                       valid_o,
  output logic [ADDR_WIDTH-1:0]      addr_c_o,
  output logic                       busy_o
);
  localparam int N = SYS_ARRAY_SIZE;
  state_t state_q, state_d;
  fetch_cnt_t cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] off;
  data_t [N-1:0] row_a, row_b;
  // cnt holds (cycle - 1) of the current operation
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + fetch_cnt_t'(1);
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    rvalid_d = state_q == READ;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = READ;
          base_a_d = addr_a_i;
          base_b_d = addr_b_i;
          base_c_d = addr_c_i;
        end
      end
      READ: state_d = cnt_q == fetch_cnt_t'(N - 1) ? COMPUTE : READ;
      COMPUTE: state_d = cnt_q == fetch_cnt_t'(FILL_CYCLES - 2) ? HANDOFF : COMPUTE;
      HANDOFF: state_d = DRAIN;
      DRAIN: if (cnt_q == fetch_cnt_t'(5 * N - 2)) begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      rvalid_q <= rvalid_d;
    end
  assign off = ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(ROW_BYTES);
  assign en_a_o = state_q == READ;
  assign en_b_o = en_a_o;
  assign addr_a_o = en_a_o ? base_a_q + off : '0;
  assign addr_b_o = en_b_o ? base_b_q + off : '0;
  assign clear_o = en_a_o && cnt_q == '0;
  assign valid_o = state_q == HANDOFF;
  assign addr_c_o = valid_o ? base_c_q : '0;
  assign busy_o = state_q != IDLE;
  // memory data is only trusted in the cycle after an enable
  assign row_a = rvalid_q ? rdata_a_i : '0;
  assign row_b = rvalid_q ? rdata_b_i : '0;
  skew_buffer u_skew_a (.clk_i(clk_i), .rst_i(rst_i), .din_i(row_a), .dout_o(a_o));
  skew_buffer u_skew_b (.clk_i(clk_i), .rst_i(rst_i), .din_i(row_b), .dout_o(b_o));
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch with a simple row memory model
module tb_operand_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i = 1'b0, start_i = 1'b0;
  logic [31:0] addr_a_i = '0, addr_b_i = '0, addr_c_i = '0;
  logic [31:0] rdata_a_i = 32'hDEADBEEF, rdata_b_i = 32'hDEADBEEF;
  logic en_a_o, en_b_o, clear_o, valid_o, busy_o;
  logic [31:0] addr_a_o, addr_b_o, addr_c_o;
  logic [3:0][7:0] a_o, b_o;
  int checks = 0, fails = 0, cyc = 0;
  typedef struct {int c; logic [31:0] a; logic [31:0] b;} rd_t;
  typedef struct {int c; logic [31:0] a;} hc_t;
  rd_t rd_q[$];
  hc_t hc_q[$];
  rd_t e_rd;
  hc_t e_hc;
  logic [31:0] nxt_a = 32'hDEADBEEF, nxt_b = 32'hDEADBEEF;

  operand_fetch dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .addr_a_i(addr_a_i), .addr_b_i(addr_b_i), .addr_c_i(addr_c_i),
    .en_a_o(en_a_o), .en_b_o(en_b_o), .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
    .rdata_a_i(rdata_a_i), .rdata_b_i(rdata_b_i), .clear_o(clear_o),
    .a_o(a_o), .b_o(b_o), .valid_o(valid_o), .addr_c_o(addr_c_o), .busy_o(busy_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] row_of(input logic [31:0] addr, input logic [7:0] off);
    logic [7:0] b;
    b = addr[7:0] + off;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // memory answers one cycle after the enable, garbage otherwise
  always @(negedge clk) begin
    nxt_a = en_a_o ? row_of(addr_a_o, 8'h00) : 32'hDEADBEEF;
    nxt_b = en_b_o ? row_of(addr_b_o, 8'h80) : 32'hDEADBEEF;
  end
  always @(posedge clk) begin
    #1;
    rdata_a_i = nxt_a;
    rdata_b_i = nxt_b;
  end

  always @(negedge clk) begin
    if (en_a_o) begin
      if (rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
      else begin
        e_rd = rd_q.pop_front();
        chk("read_cycle", cyc, e_rd.c);
        chk("addr_a_o", addr_a_o, e_rd.a);
        chk("addr_b_o", addr_b_o, e_rd.b);
        chk("en_b_o", 32'(en_b_o), 32'd1);
      end
    end
    if (valid_o) begin
      if (hc_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e_hc = hc_q.pop_front();
        chk("handoff_cycle", cyc, e_hc.c);
        chk("addr_c_o", addr_c_o, e_hc.a);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    start_i = 1'b1;
    addr_a_i = a;
    addr_b_i = b;
    addr_c_i = c;
    for (int k = 0; k < 4; k++) rd_q.push_back('{cyc + 1 + k, a + 32'(4 * k), b + 32'(4 * k)});
    hc_q.push_back('{cyc + 12, c});
  endtask

  function automatic logic [7:0] exp_lane(input int r, input int j, input logic [7:0] base);
    int k;
    k = r - 2 - j;
    return (k >= 0 && k < 4) ? base + 8'(4 * k + j) : 8'h00;
  endfunction

  task automatic cycle_check(input int r, input logic [7:0] ba, input logic [7:0] bb);
    @(negedge clk);
    chk("clear_o", 32'(clear_o), 32'(r == 1));
    chk("busy_o", 32'(busy_o), 32'(r >= 1 && r <= 19));
    chk("en_a_o", 32'(en_a_o), 32'(r >= 1 && r <= 4));
    chk("valid_o", 32'(valid_o), 32'(r == 12));
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("a_o[%0d]", j), 32'(a_o[j]), 32'(exp_lane(r, j, ba)));
      chk($sformatf("b_o[%0d]", j), 32'(b_o[j]), 32'(exp_lane(r, j, bb)));
    end
  endtask

  task automatic zero_check(input string nm);
    chk({nm, "_en"}, 32'({en_a_o, en_b_o, clear_o, valid_o, busy_o}), 32'd0);
    chk({nm, "_addr_a"}, addr_a_o, 32'd0);
    chk({nm, "_addr_b"}, addr_b_o, 32'd0);
    chk({nm, "_addr_c"}, addr_c_o, 32'd0);
    chk({nm, "_a_o"}, a_o, 32'd0);
    chk({nm, "_b_o"}, b_o, 32'd0);
  endtask

  initial begin
    #3;
    zero_check("reset");
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    tick();
    start_op(32'h100, 32'h200, 32'h300);
    tick();
    for (int r = 1; r <= 20; r++) begin
      if (r == 6) begin
        start_i = 1'b1;
        addr_a_i = 32'h500;
        addr_b_i = 32'h600;
        addr_c_i = 32'h700;
      end
      if (r == 20) start_op(32'hFFFFFFFC, 32'h200, 32'h340);
      cycle_check(r, 8'h00, 8'h80);
      tick();
    end
    for (int r = 1; r <= 20; r++) begin
      cycle_check(r, 8'hFC, 8'h80);
      tick();
    end
    start_op(32'h100, 32'h200, 32'h300);
    tick();
    for (int r = 1; r <= 6; r++) begin
      cycle_check(r, 8'h00, 8'h80);
      tick();
    end
    #2;
    rst_i = 1'b0;
    #1;
    zero_check("midop_reset");
    hc_q.delete();
    chk("reads_done_before_reset", rd_q.size(), 32'd0);
    tick();
    tick();
    zero_check("held_reset");
    rst_i = 1'b1;
    tick();
    tick();
    zero_check("after_release");
    start_op(32'h100, 32'h200, 32'h300);
    tick();
    for (int r = 1; r <= 20; r++) begin
      cycle_check(r, 8'h00, 8'h80);
      tick();
    end
    tick();
    chk("rd_q_empty", rd_q.size(), 32'd0);
    chk("hc_q_empty", hc_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL take from common_pkg: SYS_ARRAY_SIZE, default 4, array dimension N.
REQ-002 SHALL take from common_pkg: DATA_WIDTH, default 8, element width.
REQ-003 SHALL take from common_pkg: ADDR_WIDTH, default 32, byte address width.
REQ-004 SHALL take from common_pkg: ROW_BITS, default N*DATA_WIDTH, bits per memory row.
REQ-005 SHALL take from common_pkg: ROW_BYTES, default ROW_BITS/8, address stride per row.
REQ-006 clk_i  in  1  single clock; all state updates on posedge.
REQ-007 rst_i  in  1  reset, asynchronous and active-low.
REQ-008 start_i  in  1  request one N x N product.
REQ-009 addr_a_i, addr_b_i, addr_c_i  in  ADDR_WIDTH  base addresses of A, B and C.
REQ-010 en_a_o, en_b_o  out  1  memory read enables.
REQ-011 addr_a_o, addr_b_o  out  ADDR_WIDTH  memory read addresses.
REQ-012 rdata_a_i, rdata_b_i  in  ROW_BITS  read data, valid one cycle after the enable.
REQ-013 clear_o  out  1  systolic-array accumulator clear.
REQ-014 a_o, b_o  out  data_t[N]  skewed operand lanes to the array west and north edges.
REQ-015 valid_o  out  1  one-cycle handoff strobe to the write-data stage.
REQ-016 addr_c_o  out  ADDR_WIDTH  C base address, meaningful while valid_o=1.
REQ-017 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement the states IDLE, READ, COMPUTE, HANDOFF and DRAIN, with one cycle counter cnt.
REQ-019 SHALL accept start_i only in IDLE, defined as cycle 0: latch all three base addresses, clear cnt, and go to READ.
REQ-020 SHALL ignore start_i in every state other than IDLE, with no latching and no effect.
REQ-021 SHALL hold READ for cycles 1..N, driving en_a_o=en_b_o=1 and addr_x_o = base_x + k*ROW_BYTES in cycle k+1, for k=0..N-1.
REQ-022 SHALL hold en_a_o and en_b_o at 0 in every state other than READ, with addresses don't-care.
REQ-023 SHALL pulse clear_o for exactly cycle 1.
REQ-024 SHALL capture row k data in cycle k+2 and present lane j of that row on a_o[j]/b_o[j] in cycle k+2+j; lanes SHALL drive 0 in every other cycle.
REQ-025 SHALL hold COMPUTE for cycles N+1..3N-1, during which the skew continues draining zeros.
REQ-026 SHALL be in HANDOFF in cycle 3N, asserting valid_o=1 for exactly that cycle with addr_c_o = latched C base.
REQ-027 SHALL hold DRAIN for cycles 3N+1..5N-1, the 2N-1 cycles the write stage needs for N alternating WAIT/WRITE rows, and then return to IDLE at cycle 5N.
REQ-028 SHALL size cnt for 5N and SHALL NOT wrap it within one operation.
REQ-029 SHALL compute address arithmetic modulo 2^ADDR_WIDTH, with silent wrap-around.
REQ-030 SHALL accept a start_i asserted in the cycle of IDLE re-entry (cycle 5N) as cycle 0 of a new operation.

Reset
REQ-031 SHALL, on rst_i low, immediately force state IDLE, cnt 0, all skew registers 0, latched addresses 0, and all outputs 0 regardless of clock.
REQ-032 SHALL, on reset mid-operation, abandon the operation with no valid_o and require a fresh start_i after release.

Structure
REQ-033 SHALL define in common_pkg: data_t, the state enum, cycle counter type fetch_cnt_t ($clog2(5N+1) bits), and constant FILL_CYCLES=3*SYS_ARRAY_SIZE.
REQ-034 SHALL instantiate sub-module skew_buffer twice (A and B): per-lane shift register delaying lane j by j cycles, zero-filled, async-reset.

Verification (N=4, DATA_WIDTH=8, ROW_BYTES=4)
REQ-035 Basic: start at cycle 0 with addr_a=0x100, addr_b=0x200 -> addr_a_o 0x100/0x104/0x108/0x10C and addr_b_o 0x200..0x20C in cycles 1-4; clear_o high in cycle 1 only.
REQ-036 Skew: rdata_a row k = {k*4+3, k*4+2, k*4+1, k*4} -> a_o[2] = 0x02 at cycle 4 and 0x0E at cycle 7; zero at cycles 3 and 8.
REQ-037 Handoff: addr_c_i=0x300 -> valid_o=1 with addr_c_o=0x300 only in cycle 12; busy_o high in cycles 1-19 and low at cycle 20.
REQ-038 Busy start: start_i pulsed at cycle 6 with new addresses -> no effect; cycle-12 addr_c_o remains the original value.
REQ-039 Reset mid-op: rst_i low at cycle 7 -> all outputs 0 immediately, no valid_o; a new start after release behaves as in REQ-035.
REQ-040 Back-to-back and wrap: start at cycle 20 accepted; separately, addr_a_i=0xFFFFFFFC -> second read address is 0x00000000.
